avalon_master_interface: RTL and testbench

- Bridges the internal user bus (aw/w/ar/r channels, AXI-like, max 256-beat bursts) onto an Avalon-MM burst master port.
- Counterpart of the Avalon slave bridge: here user logic initiates and an external Avalon slave responds.
- Avalon read data cannot be back-pressured, so read returns go through an internal FIFO. A read is issued only when FIFO space for the whole burst is already reserved.

---
 rtl/avalon_master_interface.sv | 240 ++++++++++++++++++++++++
 tb/tb_avalon_master_interface.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_master_interface.sv
// User-bus (aw/w/ar/r) to Avalon-MM burst master bridge.
// Reads are issued only once FIFO credit for the whole burst is reserved, since
// Avalon read data cannot be stalled.
module avalon_master_interface #(
    parameter int C_AVM_ADDR_WIDTH      = 32,
    parameter int C_AVM_DATA_WIDTH      = 32,
    parameter int C_RFIFO_ADDR_WIDTH    = 8,
    parameter int C_MAX_OUTSTANDING_LOG = 2
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    // write address / data
    input  logic [C_AVM_ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]                    awlen,
    input  logic                          awvalid,
    output logic                          awready,
    input  logic [C_AVM_DATA_WIDTH-1:0]   wdata,
    input  logic [C_AVM_DATA_WIDTH/8-1:0] wstrb,
    input  logic                          wlast,
    input  logic                          wvalid,
    output logic                          wready,
    // read address / data
    input  logic [C_AVM_ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]                    arlen,
    input  logic                          arvalid,
    output logic                          arready,
    output logic [C_AVM_DATA_WIDTH-1:0]   rdata,
    output logic                          rlast,
    output logic                          rvalid,
    input  logic                          rready,
    // Avalon-MM master
    output logic [C_AVM_ADDR_WIDTH-1:0]   avm_address,
    input  logic                          avm_waitrequest,
    output logic [C_AVM_DATA_WIDTH/8-1:0] avm_byteenable,
    output logic [8:0]                    avm_burstcount,
    output logic                          avm_read,
    input  logic [C_AVM_DATA_WIDTH-1:0]   avm_readdata,
    input  logic                          avm_readdatavalid,
    output logic                          avm_write,
    output logic [C_AVM_DATA_WIDTH-1:0]   avm_writedata
);

    localparam int BE_W     = C_AVM_DATA_WIDTH / 8;
    localparam int RF_AW    = C_RFIFO_ADDR_WIDTH;
    localparam int RF_DEPTH = 1 << RF_AW;
    localparam int LQ_AW    = C_MAX_OUTSTANDING_LOG;
    localparam int LQ_DEPTH = 1 << LQ_AW;
    localparam int CW       = RF_AW + 1;

    typedef enum logic [1:0] {IDLE, WRITE, RD_CMD} state_t;

    state_t          state;
    logic            last_grant_rd;
    logic [8:0]      wcount;
    logic [BE_W-1:0] be_q;
    logic [CW-1:0]   credit;

    logic [8:0] aw_beats;
    logic [8:0] ar_beats;
    logic       w_cand;
    logic       r_cand;
    logic       grant_w;
    logic       grant_r;
    logic       w_beat;
    logic       lq_full;

    logic unused_inputs;
    assign unused_inputs = wlast;

    assign aw_beats = {1'b0, awlen} + 9'd1;
    assign ar_beats = {1'b0, arlen} + 9'd1;

    assign w_cand = awvalid;
    assign r_cand = arvalid && (credit >= CW'(ar_beats)) && !lq_full;

    // Round-robin on conflict: the side not granted last time wins.
    assign grant_w = !ARESET && (state == IDLE) && w_cand && (!r_cand || last_grant_rd);
    assign grant_r = !ARESET && (state == IDLE) && r_cand && (!w_cand || !last_grant_rd);

    assign awready = grant_w;
    assign arready = grant_r;

    assign w_beat        = (state == WRITE) && wvalid && !avm_waitrequest;
    assign wready        = !ARESET && (state == WRITE) && !avm_waitrequest;
    assign avm_write     = !ARESET && (state == WRITE) && wvalid;
    assign avm_writedata = wdata;
    assign avm_read      = !ARESET && (state == RD_CMD);
    assign avm_byteenable = (!ARESET && state == WRITE) ? wstrb : be_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state          <= IDLE;
            last_grant_rd  <= 1'b1;
            wcount         <= '0;
            avm_address    <= '0;
            avm_burstcount <= '0;
            be_q           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_w) begin
                        avm_address    <= awaddr;
                        avm_burstcount <= aw_beats;
                        wcount         <= aw_beats;
                        last_grant_rd  <= 1'b0;
                        state          <= WRITE;
                    end else if (grant_r) begin
                        avm_address    <= araddr;
                        avm_burstcount <= ar_beats;
                        be_q           <= '1;
                        last_grant_rd  <= 1'b1;
                        state          <= RD_CMD;
                    end
                end
                WRITE: begin
                    // wcount, not wlast, decides where the burst ends.
                    if (w_beat) begin
                        wcount <= wcount - 9'd1;
                        if (wcount == 9'd1) state <= IDLE;
                    end
                end
                RD_CMD: begin
                    if (!avm_waitrequest) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------- length queue of outstanding read bursts ----------------
    logic [8:0]     lq_mem [LQ_DEPTH];
    logic [LQ_AW-1:0] lq_wp;
    logic [LQ_AW-1:0] lq_rp;
    logic [LQ_AW:0]   lq_count;
    logic           lq_push;
    logic           lq_pop;

    logic           rtn_active;
    logic [8:0]     rtn_count;
    logic [8:0]     rtn_cur;
    logic           rtn_take;
    logic           rtn_last;

    assign lq_full  = (lq_count == (LQ_AW+1)'(LQ_DEPTH));
    assign lq_push  = grant_r;
    assign rtn_cur  = rtn_active ? rtn_count : lq_mem[lq_rp];
    // Returns with no burst outstanding are dropped.
    assign rtn_take = avm_readdatavalid && (rtn_active || lq_count != '0);
    assign rtn_last = (rtn_cur == 9'd1);
    assign lq_pop   = rtn_take && rtn_last;

    always_ff @(posedge ACLK) begin
        if (lq_push) lq_mem[lq_wp] <= ar_beats;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            lq_wp      <= '0;
            lq_rp      <= '0;
            lq_count   <= '0;
            rtn_active <= 1'b0;
            rtn_count  <= '0;
        end else begin
            if (lq_push) lq_wp <= lq_wp + 1'b1;
            if (lq_pop)  lq_rp <= lq_rp + 1'b1;
            lq_count <= lq_count + {{LQ_AW{1'b0}}, lq_push} - {{LQ_AW{1'b0}}, lq_pop};
            if (rtn_take) begin
                rtn_active <= !rtn_last;
                rtn_count  <= rtn_cur - 9'd1;
            end
        end
    end

    // ---------------- read return FIFO with registered output ----------------
    logic [C_AVM_DATA_WIDTH:0] rf_mem [RF_DEPTH];
    logic [RF_AW-1:0] rf_wp;
    logic [RF_AW-1:0] rf_rp;
    logic [RF_AW:0]   rf_count;
    logic           rf_empty;
    logic           rf_full;
    logic           out_load;
    logic           rf_rd;
    logic           rf_wr;
    logic           pop_out;

    assign rf_empty = (rf_count == '0);
    assign rf_full  = (rf_count == (RF_AW+1)'(RF_DEPTH));
    assign out_load = !rvalid || rready;
    assign rf_rd    = out_load && !rf_empty;
    // An idle output stage takes the incoming beat directly, bypassing memory.
    assign rf_wr    = rtn_take && !(out_load && rf_empty);
    assign pop_out  = rvalid && rready;

    always_ff @(posedge ACLK) begin
        if (rf_wr) rf_mem[rf_wp] <= {avm_readdata, rtn_last};
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rf_wp    <= '0;
            rf_rp    <= '0;
            rf_count <= '0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rlast    <= 1'b0;
        end else begin
            if (rf_wr) rf_wp <= rf_wp + 1'b1;
            if (rf_rd) rf_rp <= rf_rp + 1'b1;
            rf_count <= rf_count + {{RF_AW{1'b0}}, rf_wr} - {{RF_AW{1'b0}}, rf_rd};
            if (out_load) begin
                if (!rf_empty) begin
                    {rdata, rlast} <= rf_mem[rf_rp];
                    rvalid         <= 1'b1;
                end else if (rtn_take) begin
                    rdata  <= avm_readdata;
                    rlast  <= rtn_last;
                    rvalid <= 1'b1;
                end else begin
                    rvalid <= 1'b0;
                end
            end
        end
    end

    // Credit counts free return slots; reserve on read grant, release on pop.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            credit <= CW'(RF_DEPTH);
        end else begin
            credit <= credit - (grant_r ? CW'(ar_beats) : '0) + {{(CW-1){1'b0}}, pop_out};
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge ACLK) begin
        if (!ARESET) assert (!(rf_wr && rf_full)) else $error("read FIFO overflow");
    end
`endif

endmodule

// File: tb/tb_avalon_master_interface.sv
// Directed bench for avalon_master_interface: write/read bursts, stalls,
// credit back-pressure, arbitration and mid-burst reset.
module tb_avalon_master_interface;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [31:0] avm_address;
    logic        avm_waitrequest;
    logic [3:0]  avm_byteenable;
    logic [8:0]  avm_burstcount;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        avm_write;
    logic [31:0] avm_writedata;

    always #5 ACLK = ~ACLK;

    avalon_master_interface dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .avm_address(avm_address), .avm_waitrequest(avm_waitrequest),
        .avm_byteenable(avm_byteenable), .avm_burstcount(avm_burstcount),
        .avm_read(avm_read), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .avm_write(avm_write),
        .avm_writedata(avm_writedata)
    );

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Avalon write-beat capture
    int          cap_n = 0;
    logic [31:0] cap_d [64];
    logic [31:0] cap_a [64];
    logic [8:0]  cap_bc[64];
    always @(posedge ACLK) begin
        if (!ARESET && avm_write && !avm_waitrequest && cap_n < 64) begin
            cap_d[cap_n]  = avm_writedata;
            cap_a[cap_n]  = avm_address;
            cap_bc[cap_n] = avm_burstcount;
            cap_n = cap_n + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    int          base;
    int          i;
    int          errs;
    int          lastc;
    int          lasti;
    int          gn;
    int          both;
    logic        s3, s7, g;
    logic [3:0]  gw;
    logic [31:0] t4d [6];
    logic        t4l [6];

    initial begin
        ARESET = 1'b1;
        awaddr = '0; awlen = '0; awvalid = 1'b1; wdata = '0; wstrb = '0; wlast = 1'b0;
        wvalid = 1'b0; araddr = '0; arlen = '0; arvalid = 1'b1; rready = 1'b0;
        avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0;
        repeat (3) tick();
        settle();
        chk("rst_awready", awready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_avm_read", avm_read, 0);
        chk("rst_avm_write", avm_write, 0);
        chk("rst_address", avm_address, 0);
        chk("rst_burstcount", avm_burstcount, 0);
        chk("rst_byteenable", avm_byteenable, 0);
        awvalid = 1'b0; arvalid = 1'b0; ARESET = 1'b0;
        tick();

        // single write
        awaddr = 32'h100; awlen = 8'd0; awvalid = 1'b1;
        settle();
        chk("t1_awready", awready, 1);
        tick();
        awaddr = 32'h180; wvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hA;
        settle();
        chk("t1_awready_busy", awready, 0);
        chk("t1_avm_write", avm_write, 1);
        chk("t1_writedata", avm_writedata, 32'hDEADBEEF);
        chk("t1_byteenable", avm_byteenable, 4'hA);
        chk("t1_burstcount", avm_burstcount, 1);
        chk("t1_address", avm_address, 32'h100);
        chk("t1_wready", wready, 1);
        base = cap_n;
        tick();
        wvalid = 1'b0;
        settle();
        chk("t1_awready_again", awready, 1);
        chk("t1_write_done", avm_write, 0);
        chk("t1_beats", cap_n - base, 1);
        awvalid = 1'b0;
        tick();

        // 16-beat write with two waitrequest stalls and one wvalid gap
        awaddr = 32'h200; awlen = 8'd15; awvalid = 1'b1;
        settle();
        chk("t2_awready", awready, 1);
        base = cap_n;
        tick();
        awvalid = 1'b0;
        i = 0; s3 = 1'b0; s7 = 1'b0; g = 1'b0;
        for (int c = 0; c < 40 && i < 16; c++) begin
            wvalid = 1'b1; wdata = 32'h1000 + i; wstrb = 4'hF; avm_waitrequest = 1'b0;
            if (i == 3 && !s3) begin avm_waitrequest = 1'b1; s3 = 1'b1; end
            else if (i == 7 && !s7) begin avm_waitrequest = 1'b1; s7 = 1'b1; end
            else if (i == 10 && !g) begin wvalid = 1'b0; g = 1'b1; end
            settle();
            if (avm_waitrequest) chk($sformatf("t2_wready_stall_%0d", i), wready, 0);
            if (wvalid && !avm_waitrequest) i = i + 1;
            tick();
        end
        avm_waitrequest = 1'b0;
        settle();
        chk("t2_idle_after_16", avm_write, 0);
        wvalid = 1'b0;
        chk("t2_beats", cap_n - base, 16);
        errs = 0;
        for (int k = 0; k < 16; k++) begin
            if (cap_d[base+k] !== 32'h1000 + k || cap_a[base+k] !== 32'h200 || cap_bc[base+k] !== 9'd16)
                errs = errs + 1;
        end
        chk("t2_order_addr_bc", errs, 0);
        tick();

        // 256-beat read with rready low: full buffering, credit exhausted
        araddr = 32'h4000; arlen = 8'd255; arvalid = 1'b1;
        settle();
        chk("t3_arready", arready, 1);
        tick();
        arvalid = 1'b0; avm_waitrequest = 1'b1;
        settle();
        chk("t3_avm_read", avm_read, 1);
        chk("t3_burstcount", avm_burstcount, 9'h100);
        chk("t3_address", avm_address, 32'h4000);
        chk("t3_byteenable", avm_byteenable, 4'hF);
        tick();
        avm_waitrequest = 1'b0;
        settle();
        chk("t3_read_held", avm_read, 1);
        tick();
        chk("t3_read_done", avm_read, 0);
        arvalid = 1'b1; arlen = 8'd0; araddr = 32'h5000;
        settle();
        chk("t3_no_credit", arready, 0);
        for (int k = 0; k < 256; k++) begin
            avm_readdatavalid = 1'b1; avm_readdata = 32'h5000 + k;
            tick();
        end
        avm_readdatavalid = 1'b0;
        settle();
        chk("t3_still_no_credit", arready, 0);
        chk("t3_first_rvalid", rvalid, 1);
        chk("t3_first_rdata", rdata, 32'h5000);
        chk("t3_first_rlast", rlast, 0);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        settle();
        chk("t3_credit_back", arready, 1);
        arvalid = 1'b0;
        settle();
        rready = 1'b1; errs = 0; lastc = 0; lasti = -1;
        for (int k = 1; k < 256; k++) begin
            settle();
            if (!rvalid || rdata !== 32'h5000 + k) errs = errs + 1;
            if (rlast) begin lastc = lastc + 1; lasti = k; end
            tick();
        end
        rready = 1'b0;
        settle();
        chk("t3_data", errs, 0);
        chk("t3_rlast_count", lastc, 1);
        chk("t3_rlast_index", lasti, 255);
        chk("t3_empty", rvalid, 0);

        // two reads (4 then 2 beats) with returns interleaved with commands
        t4d = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hB0, 32'hB1};
        t4l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        araddr = 32'h800; arlen = 8'd3; arvalid = 1'b1;
        settle();
        chk("t4_arready_a", arready, 1);
        tick();
        arvalid = 1'b0;
        settle();
        chk("t4_read_a", avm_read, 1);
        chk("t4_bc_a", avm_burstcount, 4);
        tick();
        araddr = 32'h900; arlen = 8'd1; arvalid = 1'b1;
        avm_readdatavalid = 1'b1; avm_readdata = 32'hA0;
        settle();
        chk("t4_arready_b", arready, 1);
        tick();
        arvalid = 1'b0; avm_readdata = 32'hA1;
        settle();
        chk("t4_bc_b", avm_burstcount, 2);
        tick();
        avm_readdata = 32'hA2; tick();
        avm_readdatavalid = 1'b0; tick();
        avm_readdatavalid = 1'b1; avm_readdata = 32'hA3; tick();
        avm_readdata = 32'hB0; tick();
        avm_readdata = 32'hB1; tick();
        avm_readdatavalid = 1'b0;
        rready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            settle();
            chk($sformatf("t4_rdata_%0d", k), rdata, t4d[k]);
            chk($sformatf("t4_rlast_%0d", k), rlast, t4l[k]);
            if (k == 5) begin
                arvalid = 1'b1; arlen = 8'd255;
                settle();
                chk("t4_credit_255", arready, 0);
                arvalid = 1'b0;
            end
            tick();
        end
        rready = 1'b0;
        arvalid = 1'b1; arlen = 8'd255;
        settle();
        chk("t4_credit_256", arready, 1);
        arvalid = 1'b0;
        tick();

        // alternating grants with both requests held
        awaddr = 32'hA00; awlen = 8'd0; awvalid = 1'b1;
        araddr = 32'hB00; arlen = 8'd0; arvalid = 1'b1;
        wvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF;
        gw = '0; gn = 0; both = 0;
        for (int c = 0; c < 20 && gn < 4; c++) begin
            settle();
            if (awready && arready) both = both + 1;
            if (awready) begin gw[gn] = 1'b1; gn = gn + 1; end
            else if (arready) begin gw[gn] = 1'b0; gn = gn + 1; end
            tick();
        end
        awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b0;
        chk("t5_grant_count", gn, 4);
        chk("t5_grant_order", gw, 4'b0101);
        chk("t5_no_double", both, 0);
        tick();
        tick();

        // reset during beat 5 of an 8-beat write, then a stray return
        awaddr = 32'h300; awlen = 8'd7; awvalid = 1'b1;
        settle();
        chk("t6_awready", awready, 1);
        base = cap_n;
        tick();
        awvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wvalid = 1'b1; wdata = 32'h600 + k;
            tick();
        end
        wdata = 32'h605; ARESET = 1'b1;
        settle();
        chk("t6_write_in_reset", avm_write, 0);
        chk("t6_wready_in_reset", wready, 0);
        tick();
        ARESET = 1'b0; wvalid = 1'b0;
        settle();
        chk("t6_avm_write", avm_write, 0);
        chk("t6_wready", wready, 0);
        chk("t6_address", avm_address, 0);
        chk("t6_burstcount", avm_burstcount, 0);
        chk("t6_byteenable", avm_byteenable, 0);
        chk("t6_rvalid", rvalid, 0);
        chk("t6_avm_read", avm_read, 0);
        chk("t6_beats_before_reset", cap_n - base, 5);
        avm_readdatavalid = 1'b1; avm_readdata = 32'hBAD;
        tick();
        avm_readdatavalid = 1'b0;
        tick();
        settle();
        chk("t6_stray_dropped", rvalid, 0);
        awaddr = 32'h400; awlen = 8'd0; awvalid = 1'b1;
        settle();
        chk("t6_new_awready", awready, 1);
        tick();
        awvalid = 1'b0; wvalid = 1'b1; wdata = 32'h77; wstrb = 4'h3;
        settle();
        chk("t6_new_address", avm_address, 32'h400);
        chk("t6_new_burstcount", avm_burstcount, 1);
        chk("t6_new_byteenable", avm_byteenable, 4'h3);
        base = cap_n;
        tick();
        wvalid = 1'b0;
        settle();
        chk("t6_new_beats", cap_n - base, 1);
        chk("t6_new_data", cap_d[base], 32'h77);
        chk("t6_new_done", avm_write, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
